// File: rtl/note_sequencer.sv
// note_sequencer: fetches 16-bit music instructions from asynchronous SRAM and
// drives CHANNELS independent square-wave voices plus one OR-mixed speaker line.
// Instructions: NOTE (load a voice), WAIT (play for N beats, with a muted gap at
// the end), JUMP (looping) and END (silence everything and halt until reset).
// Optional build macro: TEMPO_PORT_EN adds a BEAT_CYCLES input that sets the
// beat length of each WAIT instead of the CLK_HZ/BPM derived constant.
module note_sequencer #(
   parameter int CLK_HZ     = 50000000,
   parameter int BPM        = 96,
   parameter int CHANNELS   = 4,
   parameter int GAP_CYCLES = 5000000,
   parameter int ADDR_W     = 18
) (
   input  logic                CLK,
   input  logic                RST_N,
`ifdef TEMPO_PORT_EN
   input  logic [31:0]         BEAT_CYCLES,
`endif
   output logic [ADDR_W-1:0]   SRAM_A,
   input  logic [15:0]         SRAM_D,
   output logic                SRAM_WE,
   output logic                SRAM_CE,
   output logic                SRAM_OE,
   output logic                SRAM_LB,
   output logic                SRAM_UB,
   output logic [CHANNELS-1:0] SPEAKER_CH,
   output logic                SPEAKER,
   output logic                DONE,
   output logic [ADDR_W-1:0]   PC_DBG
);

   // Wide intermediates keep CLK_HZ*60 and CLK_HZ*1000 from overflowing 32 bits.
   localparam logic [63:0] CLK_MILLI       = 64'(CLK_HZ) * 64'd1000;
   localparam logic [31:0] CYCLES_PER_BEAT = 32'(64'(CLK_HZ) * 64'd60 / 64'(BPM));
   localparam logic [31:0] GAP_LEN         = 32'(GAP_CYCLES);

   localparam logic [1:0] OP_NOTE = 2'b00;
   localparam logic [1:0] OP_WAIT = 2'b01;
   localparam logic [1:0] OP_JUMP = 2'b10;
   localparam logic [1:0] OP_END  = 2'b11;

   typedef enum logic [2:0] {
      F_ADDR  = 3'd0,
      F_WAIT  = 3'd1,
      F_LATCH = 3'd2,
      PLAY    = 3'd3,
      HALT    = 3'd4
   } state_t;

   // Octave-0 period (C4..B4) in clock cycles; all operands are constants so
   // each entry folds to a literal.
   function automatic logic [31:0] base_period(input logic [3:0] n);
      case (n)
         4'd0:    base_period = 32'(CLK_MILLI / 64'd261626);
         4'd1:    base_period = 32'(CLK_MILLI / 64'd277183);
         4'd2:    base_period = 32'(CLK_MILLI / 64'd293665);
         4'd3:    base_period = 32'(CLK_MILLI / 64'd311127);
         4'd4:    base_period = 32'(CLK_MILLI / 64'd329628);
         4'd5:    base_period = 32'(CLK_MILLI / 64'd349228);
         4'd6:    base_period = 32'(CLK_MILLI / 64'd369994);
         4'd7:    base_period = 32'(CLK_MILLI / 64'd391995);
         4'd8:    base_period = 32'(CLK_MILLI / 64'd415305);
         4'd9:    base_period = 32'(CLK_MILLI / 64'd440000);
         4'd10:   base_period = 32'(CLK_MILLI / 64'd466164);
         4'd11:   base_period = 32'(CLK_MILLI / 64'd493883);
         default: base_period = 32'd0;
      endcase
   endfunction

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W-1:0]   sram_a_q, sram_a_d;
   logic                done_q, done_d;
   logic [31:0]         beat_cnt_q, beat_cnt_d;
   logic [31:0]         play_last_q, play_last_d;
   logic [31:0]         mute_start_q, mute_start_d;
   logic [CHANNELS-1:0] active_q, active_d;
   logic [31:0]         period_q [CHANNELS];
   logic [31:0]         period_d [CHANNELS];
   logic [31:0]         cnt_q [CHANNELS];
   logic [31:0]         cnt_d [CHANNELS];
   logic [CHANNELS-1:0] spk_q, spk_d;
   logic                speaker_q, speaker_d;

   logic [1:0]          op_s;
   logic [1:0]          ch_s;
   logic [1:0]          oct_s;
   logic [3:0]          note_s;
   logic [7:0]          beats_s;
   logic [31:0]         beat_len_s;
   logic [31:0]         play_len_s;
   logic [ADDR_W-1:0]   jump_target_s;
   logic                note_on_s;
   logic [31:0]         note_period_s;
   logic                note_latch_s;
   logic                silence_all_s;
   logic                mute_s;
   logic [CHANNELS-1:0] load_s;

   // Field extraction and derived values for the instruction on SRAM_D.
   always_comb begin
      op_s          = SRAM_D[15:14];
      ch_s          = SRAM_D[13:12];
      oct_s         = SRAM_D[5:4];
      note_s        = SRAM_D[3:0];
      beats_s       = (SRAM_D[7:0] == 8'd0) ? 8'd1 : SRAM_D[7:0];
`ifdef TEMPO_PORT_EN
      beat_len_s    = (BEAT_CYCLES == 32'd0) ? 32'd1 : BEAT_CYCLES;
`else
      beat_len_s    = CYCLES_PER_BEAT;
`endif
      play_len_s    = {24'd0, beats_s} * beat_len_s;
      jump_target_s = ADDR_W'({{ADDR_W{1'b0}}, SRAM_D[13:0]});
      note_on_s     = (note_s < 4'd12);
      note_period_s = base_period(note_s) >> oct_s;
   end

   // Fetch/decode/play sequencer: next state, program counter and play timing.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      sram_a_d      = sram_a_q;
      done_d        = done_q;
      beat_cnt_d    = beat_cnt_q;
      play_last_d   = play_last_q;
      mute_start_d  = mute_start_q;
      note_latch_s  = 1'b0;
      silence_all_s = 1'b0;
      case (state_q)
         F_ADDR: begin
            sram_a_d = pc_q;
            state_d  = F_WAIT;
         end
         F_WAIT: begin
            state_d = F_LATCH;
         end
         F_LATCH: begin
            pc_d = pc_q + ADDR_W'(1);
            case (op_s)
               OP_NOTE: begin
                  note_latch_s = 1'b1;
                  state_d      = F_ADDR;
               end
               OP_WAIT: begin
                  beat_cnt_d   = 32'd0;
                  play_last_d  = play_len_s - 32'd1;
                  mute_start_d = (GAP_LEN >= play_len_s) ? 32'd0 : (play_len_s - GAP_LEN);
                  state_d      = PLAY;
               end
               OP_JUMP: begin
                  pc_d    = jump_target_s;
                  state_d = F_ADDR;
               end
               OP_END: begin
                  done_d        = 1'b1;
                  silence_all_s = 1'b1;
                  state_d       = HALT;
               end
               default: begin
                  state_d = F_ADDR;
               end
            endcase
         end
         PLAY: begin
            if (beat_cnt_q == play_last_q) begin
               beat_cnt_d = 32'd0;
               state_d    = F_ADDR;
            end else begin
               beat_cnt_d = beat_cnt_q + 32'd1;
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = F_ADDR;
         end
      endcase
   end

   // Gap mute: the tail of every WAIT period silences all voices.
   always_comb begin
      mute_s = (state_q == PLAY) && (beat_cnt_q >= mute_start_q);
   end

   // Voice loading, wave counters and per-voice square-wave levels.
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         load_s[c]   = note_latch_s && (ch_s == 2'(c));
         active_d[c] = active_q[c];
         period_d[c] = period_q[c];
         if (load_s[c]) begin
            active_d[c] = note_on_s;
            period_d[c] = note_period_s;
            cnt_d[c]    = 32'd0;
         end else if (silence_all_s) begin
            active_d[c] = 1'b0;
            cnt_d[c]    = 32'd0;
         end else if (!active_q[c] || mute_s || (period_q[c] < 32'd2)) begin
            cnt_d[c] = 32'd0;
         end else if (cnt_q[c] == (period_q[c] - 32'd1)) begin
            cnt_d[c] = 32'd0;
         end else begin
            cnt_d[c] = cnt_q[c] + 32'd1;
         end
         spk_d[c] = active_q[c] && !mute_s && (cnt_q[c] < (period_q[c] >> 1));
      end
      speaker_d = |spk_d;
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= F_ADDR;
         pc_q         <= {ADDR_W{1'b0}};
         sram_a_q     <= {ADDR_W{1'b0}};
         done_q       <= 1'b0;
         beat_cnt_q   <= 32'd0;
         play_last_q  <= 32'd0;
         mute_start_q <= 32'd0;
         active_q     <= {CHANNELS{1'b0}};
         spk_q        <= {CHANNELS{1'b0}};
         speaker_q    <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            period_q[c] <= 32'd0;
            cnt_q[c]    <= 32'd0;
         end
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         sram_a_q     <= sram_a_d;
         done_q       <= done_d;
         beat_cnt_q   <= beat_cnt_d;
         play_last_q  <= play_last_d;
         mute_start_q <= mute_start_d;
         active_q     <= active_d;
         spk_q        <= spk_d;
         speaker_q    <= speaker_d;
         for (int c = 0; c < CHANNELS; c++) begin
            period_q[c] <= period_d[c];
            cnt_q[c]    <= cnt_d[c];
         end
      end
   end

   assign SRAM_A     = sram_a_q;
   assign SRAM_WE    = 1'b1;
   assign SRAM_CE    = 1'b0;
   assign SRAM_OE    = 1'b0;
   assign SRAM_LB    = 1'b0;
   assign SRAM_UB    = 1'b0;
   assign SPEAKER_CH = spk_q;
   assign SPEAKER    = speaker_q;
   assign DONE       = done_q;
   assign PC_DBG     = pc_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: scoreboard bench for note_sequencer. Stimulus loads small
// SRAM programs and queues the expected output events (voice edges, PC changes,
// DONE) with the cycle they should appear on; a monitor pops and compares.
// Clock 1 MHz nominal, BPM 10000 -> 6000 cycles per beat, 1000-cycle gap.
module tb_note_sequencer;

   localparam int AW = 18;

   typedef struct {
      int sid;
      int val;
      int cyc;
   } ev_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int          cyc;
   int          n_cmp = 0;
   int          n_bad = 0;
   ev_t         exp_q [$];
   string       sname [9] = '{"ch0", "ch1", "ch2", "ch3", "d2_ch0", "d2_ch1", "pc", "done", "spare"};

   logic [15:0] mem4 [16];
   logic [15:0] mem2 [16];

   logic [AW-1:0] a4, pc4, a2, pc2;
   logic [15:0]   d4, d2;
   logic          we4, ce4, oe4, lb4, ub4, spk4, done4;
   logic          we2, ce2, oe2, lb2, ub2, spk2, done2;
   logic [3:0]    ch4, prev_ch4;
   logic [1:0]    ch2, prev_ch2;
   logic [AW-1:0] prev_pc4;
   logic          prev_done4, prev_spk4, prev_spk2;

   assign d4 = mem4[a4[3:0]];
   assign d2 = mem2[a2[3:0]];

   note_sequencer #(.CLK_HZ(1000000), .BPM(10000), .CHANNELS(4), .GAP_CYCLES(1000), .ADDR_W(AW)) dut4 (
      .CLK(clk), .RST_N(rst_n), .SRAM_A(a4), .SRAM_D(d4), .SRAM_WE(we4), .SRAM_CE(ce4),
      .SRAM_OE(oe4), .SRAM_LB(lb4), .SRAM_UB(ub4), .SPEAKER_CH(ch4), .SPEAKER(spk4),
      .DONE(done4), .PC_DBG(pc4));

   note_sequencer #(.CLK_HZ(1000000), .BPM(10000), .CHANNELS(2), .GAP_CYCLES(1000), .ADDR_W(AW)) dut2 (
      .CLK(clk), .RST_N(rst_n), .SRAM_A(a2), .SRAM_D(d2), .SRAM_WE(we2), .SRAM_CE(ce2),
      .SRAM_OE(oe2), .SRAM_LB(lb2), .SRAM_UB(ub2), .SPEAKER_CH(ch2), .SPEAKER(spk2),
      .DONE(done2), .PC_DBG(pc2));

   always #5 clk = ~clk;

   // Cycle count since reset release: 1 after the first rising edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic push(input int sid, input int val, input int at);
      ev_t e;
      e.sid = sid;
      e.val = val;
      e.cyc = at;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int sid, input int val, input int at);
      int idx;
      idx = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (idx < 0 && exp_q[i].sid == sid) idx = i;
      end
      n_cmp++;
      if (idx < 0) begin
         n_bad++;
         $display("FAIL %s unexpected: got %0d at cycle %0d, none required", sname[sid], val, at);
      end else begin
         if (exp_q[idx].val != val || exp_q[idx].cyc != at) begin
            n_bad++;
            $display("FAIL %s: got %0d at cycle %0d, required %0d at cycle %0d",
                     sname[sid], val, at, exp_q[idx].val, exp_q[idx].cyc);
         end
         exp_q.delete(idx);
      end
   endtask

   // Monitor: every change of a watched output is matched against the queue.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int c = 0; c < 4; c++) if (ch4[c] != prev_ch4[c]) observe(c, int'(ch4[c]), cyc);
         for (int c = 0; c < 2; c++) if (ch2[c] != prev_ch2[c]) observe(4 + c, int'(ch2[c]), cyc);
         if (pc4 != prev_pc4) observe(6, int'(pc4), cyc);
         if (done4 != prev_done4) observe(7, int'(done4), cyc);
         if (ch4 != prev_ch4 || spk4 != prev_spk4) check("speaker_or4", spk4, |ch4);
         if (ch2 != prev_ch2 || spk2 != prev_spk2) check("speaker_or2", spk2, |ch2);
      end
      prev_ch4   <= ch4;
      prev_ch2   <= ch2;
      prev_pc4   <= pc4;
      prev_done4 <= done4;
      prev_spk4  <= spk4;
      prev_spk2  <= spk2;
   end

   task automatic start_phase();
      rst_n = 1'b0;
      for (int i = 0; i < 16; i++) begin
         mem4[i] = 16'hC000;
         mem2[i] = 16'hC000;
      end
   endtask

   task automatic release_rst();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic end_phase(input string name);
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      // Phase 1: fetch timing, A4 on ch0, WAIT 1 with gap, END at address 3.
      // Second DUT (2 channels) ignores NOTEs to ch3 and ch2.
      start_phase();
      mem4[0] = 16'h0009; mem4[1] = 16'h4001; mem4[2] = 16'h200C; mem4[3] = 16'hC000;
      mem2[0] = 16'h3009; mem2[1] = 16'h1009; mem2[2] = 16'h2009; mem2[3] = 16'hC000;
      push(6, 1, 3); push(6, 2, 6); push(6, 3, 6009); push(6, 4, 6012); push(7, 1, 6012);
      push(0, 1, 4); push(0, 0, 1140); push(0, 1, 2276); push(0, 0, 3412);
      push(0, 1, 4548); push(0, 0, 5007); push(0, 1, 6007); push(0, 0, 6013);
      push(5, 1, 7); push(5, 0, 13);
      release_rst();
      wait_cyc(1);
      check("sram_a_cycle1", a4, 0);
      wait_cyc(4);
      check("sram_a_cycle4", a4, 1);
      wait_cyc(6100);
      check("end_done", done4, 1);
      check("end_sram_a_frozen", a4, 3);
      check("end_voices", ch4, 0);
      check("end_speaker", spk4, 0);
      check("sram_ctrl", {we4, ce4, oe4, lb4, ub4}, 5'b10000);
      check("d2_done", done2, 1);
      check("d2_pc", pc2, 4);
      check("d2_voices", ch2, 0);
      end_phase("leftover_p1");

      // Phase 2: ch1 note 9 octave 2 (period 568), WAIT 2 = 12000 cycles.
      start_phase();
      mem4[0] = 16'h1029; mem4[1] = 16'h4002; mem4[2] = 16'hC000;
      push(6, 1, 3); push(6, 2, 6); push(6, 3, 12009); push(7, 1, 12009);
      for (int k = 0; k < 20; k++) begin
         push(1, 1, 4 + 568 * k);
         if (k < 19) push(1, 0, 288 + 568 * k);
      end
      push(1, 0, 11007); push(1, 1, 12007); push(1, 0, 12010);
      release_rst();
      wait_cyc(12100);
      check("p2_pc", pc4, 3);
      check("p2_sram_a", a4, 2);
      end_phase("leftover_p2");

      // Phase 3: last NOTE to ch0 wins (silence), ch3 C4, WAIT 1, JUMP 0 loop;
      // reset asserted mid-PLAY.
      start_phase();
      mem4[0] = 16'h0009; mem4[1] = 16'h000C; mem4[2] = 16'h3000;
      mem4[3] = 16'h4001; mem4[4] = 16'h8000;
      push(6, 1, 3); push(6, 2, 6); push(6, 3, 9); push(6, 4, 12);
      push(6, 0, 6015); push(6, 1, 6018); push(6, 2, 6021); push(6, 3, 6024); push(6, 4, 6027);
      push(0, 1, 4); push(0, 0, 7); push(0, 1, 6019); push(0, 0, 6022);
      push(3, 1, 10); push(3, 0, 1921); push(3, 1, 3832); push(3, 0, 5013);
      push(3, 1, 6013); push(3, 0, 7936); push(3, 1, 9847);
      release_rst();
      wait_cyc(10000);
      check("p3_high_before_reset", ch4[3], 1);
      end_phase("leftover_p3");
      #1 rst_n = 1'b0;
      #1;
      check("rst_speaker", spk4, 0);
      check("rst_voices", ch4, 0);
      check("rst_done", done4, 0);
      check("rst_sram_a", a4, 0);
      check("rst_pc", pc4, 0);

      // Phase 4: fetch resumes from address 0 after the mid-PLAY reset.
      start_phase();
      mem4[0] = 16'h2009; mem4[1] = 16'hC000;
      push(6, 1, 3); push(6, 2, 6); push(7, 1, 6); push(2, 1, 4); push(2, 0, 7);
      release_rst();
      wait_cyc(50);
      check("p4_done", done4, 1);
      end_phase("leftover_p4");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Multi-channel successor to the single-voice SRAM player. It fetches 16-bit music instructions from asynchronous SRAM and drives CHANNELS independent square-wave voices, plus one OR-mixed speaker line. Beat duration, channel count and silence gap between notes are parameters. Adds rests, multi-beat waits, jumps for looping, and a halt instruction. It sits between the SRAM pins and the speaker/LED pins at top level.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
BPM, 96, tempo; CYCLES_PER_BEAT = CLK_HZ*60/BPM (localparam, 32-bit)
CHANNELS, 4, number of voices, 1..4
GAP_CYCLES, 5000000, cycles at end of each wait period during which all voices are muted
ADDR_W, 18, SRAM address width

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
SRAM_A  out  ADDR_W  SRAM word address
SRAM_D  in  16  SRAM read data
SRAM_WE  out  1  tied 1 (read only)
SRAM_CE/SRAM_OE/SRAM_LB/SRAM_UB  out  1 each  tied 0
SPEAKER_CH  out  CHANNELS  per-voice square wave
SPEAKER  out  1  OR of SPEAKER_CH
DONE  out  1  high after END executed
PC_DBG  out  ADDR_W  current program counter

Behaviour:
- Reset is asynchronous and active-low; one clock. On RST_N=0: PC=0, SRAM_A=0, SPEAKER_CH=0, SPEAKER=0, DONE=0, all voices silent, state=F_ADDR.
- Instruction encoding, op=[15:14]:
  - 00 NOTE: ch=[13:12], octave=[5:4], note=[3:0]. Loads the voice. note>=12 silences the voice. ch>=CHANNELS: instruction is ignored (no-op).
  - 01 WAIT: beats=[7:0]; 0 is treated as 1. Voices play for beats*CYCLES_PER_BEAT cycles.
  - 10 JUMP: PC <= [13:0], zero-extended.
  - 11 END: all voices silenced; DONE=1; state HALT until reset.
- FSM:
  - F_ADDR: SRAM_A<=PC.
  - F_WAIT: 1 cycle.
  - F_LATCH: capture SRAM_D, decode. PC<=PC+1 (wraps at 2^ADDR_W), except on JUMP.
  - Next state: F_ADDR, or PLAY for WAIT, or HALT for END.
  - NOTE/JUMP/no-op therefore cost 3 cycles each. Voices keep sounding during fetch.
- PLAY: 32-bit beat-cycle counter runs to beats*CYCLES_PER_BEAT-1, then returns to F_ADDR. During the last GAP_CYCLES cycles of the period, SPEAKER_CH is forced 0 and wave counters are held at 0. If GAP_CYCLES >= the period, the whole period is muted.
- Voice period:
  - Constant table of octave-0 periods, C4..B4: P[n] = CLK_HZ*1000/F_mHz[n], integer truncation, with F_mHz = 261626, 277183, 293665, 311127, 329628, 349228, 369994, 391995, 415305, 440000, 466164, 493883.
  - Voice period = P[n] >> octave.
  - Wave counter counts 0..period-1 and wraps. Output is 1 while counter < period/2.
  - Loading a NOTE resets that voice's counter to 0 on the same edge.
- A silent voice outputs 0 and its counter is held at 0.
- A NOTE issued to the same channel by consecutive instructions: the last one wins.
- Reset mid-PLAY or mid-fetch returns to the reset state immediately (asynchronous).

Optional Feature:
TEMPO_PORT_EN
- Defined: adds input BEAT_CYCLES[31:0]. It is sampled when entering PLAY and replaces CYCLES_PER_BEAT for that wait. A value of 0 is treated as 1.
- Undefined: port is absent and the CYCLES_PER_BEAT localparam is used.

Test Plan:
Use CLK_HZ=1000000, BPM=600 (CYCLES_PER_BEAT=100000), GAP_CYCLES=1000, CHANNELS=4 unless noted.
- Reset: RST_N low mid-PLAY -> SPEAKER=0, DONE=0, SRAM_A=0 within the same cycle; fetch from address 0 resumes after release.
- Fetch timing: SRAM[0]=NOTE ch0 A4 (0x0009) -> SRAM_A=0 on cycle 1; voice loaded 3 cycles after reset release; period 2272, SPEAKER_CH[0] high 1136 cycles, low 1136 cycles.
- Octave/WAIT/gap: NOTE ch1 note9 octave2 (0x1029), then WAIT 2 (0x4002) -> SPEAKER_CH[1] period 568; PLAY lasts 200000 cycles; last 1000 cycles muted.
- Silence/ignore: NOTE ch0 note=12 -> SPEAKER_CH[0] stays 0. With CHANNELS=2, NOTE ch3 -> no voice changes.
- JUMP loop: program [NOTE, WAIT 1, JUMP 0] -> PC_DBG sequence 0,1,2,0,... with no DONE; SPEAKER equals the OR of voices.
- END: 0xC000 at address 3 -> DONE=1, all outputs 0, SRAM_A frozen until reset. Under TEMPO_PORT_EN, BEAT_CYCLES=500 makes WAIT 1 last 500 cycles.
